controle_janela: RTL and testbench

- Gate-time sequencer for the frequency meter datapath (BCD decade counter + output register bank).
- Drives the counter's clear/enable and the register's store strobe from a precise window counted on the reference clock, replacing the free-running clock-mux stepping.
- Optional autorange: shortens the gate on counter overflow and lengthens it on under-range.

---
 rtl/freq_pkg.sv | 20 ++
 rtl/contador_janela.sv | 48 ++++
 rtl/controle_janela.sv | 135 +++++++++++++
 tb/tb_controle_janela.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency meter gate sequencer.
//   estado_t   : sequencer states
//   faixa_t    : 2-bit gate range index (range r gate = BASE_TICKS * 10^r cycles)
//   DECADA_LIM : number of base units per gate for each range
package freq_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      LIMPA,
      JANELA,
      ESPERA,
      ARMAZENA,
      AJUSTE
   } estado_t;

   typedef logic [1:0] faixa_t;

   localparam logic [9:0] DECADA_LIM [4] = '{10'd1, 10'd10, 10'd100, 10'd1000};

endpackage

// File: rtl/contador_janela.sv
// Gate window counter: a base counter (0..BASE_TICKS-1) cascaded into a decade
// counter (0..DECADA_LIM[faixa]-1). The window therefore lasts
// BASE_TICKS * DECADA_LIM[faixa] cycles after carregar is released.
//   clk      : reference clock
//   rst_n    : asynchronous active-low reset
//   carregar : synchronous clear of both counters (held during LIMPA)
//   faixa    : gate range, must stay stable for the whole window
//   fim      : high on the last cycle of the window
module contador_janela
   import freq_pkg::*;
#(
   parameter int unsigned BASE_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       carregar,
   input  logic [1:0] faixa,
   output logic       fim
);

   localparam int unsigned BW = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
   localparam logic [BW-1:0] BASE_MAX = BW'(BASE_TICKS - 1);

   logic [BW-1:0] r_base;
   logic [9:0]    r_dec;
   logic          w_base_fim;
   logic          w_dec_fim;

   assign w_base_fim = (r_base == BASE_MAX);
   assign w_dec_fim  = (r_dec == (DECADA_LIM[faixa] - 10'd1));
   assign fim        = w_base_fim & w_dec_fim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base <= '0;
         r_dec  <= '0;
      end else if (carregar) begin
         r_base <= '0;
         r_dec  <= '0;
      end else if (w_base_fim) begin
         r_base <= '0;
         r_dec  <= w_dec_fim ? 10'd0 : r_dec + 10'd1;
      end else begin
         r_base <= r_base + 1'b1;
      end
   end

endmodule

// File: rtl/controle_janela.sv
// Gate-time sequencer for the frequency meter datapath. Clears the BCD counter,
// enables it for a precise window counted on the reference clock, lets it settle
// one cycle, strobes the output register bank, and optionally autoranges.
//   clk, rst_n     : reference clock, asynchronous active-low reset
//   iniciar        : level, run continuous measurements while high
//   auto_faixa     : 1 = autorange, 0 = use faixa_manual
//   faixa_manual   : manual gate range
//   estouro        : carry out of the BCD top digit
//   msd_zero       : BCD top digit is zero
//   limpar         : clear BCD counter
//   habilitar      : BCD count enable (gate window)
//   armazena       : one-cycle store strobe to the register bank
//   valido         : one-cycle pulse, stored value is new
//   sobrecarga     : last stored value overflowed
//   faixa_atual    : range of the current/last gate
//   ocupado        : sequencer not idle
module controle_janela
   import freq_pkg::*;
#(
   parameter int unsigned BASE_TICKS = 1000,
   parameter int unsigned NUM_FAIXAS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iniciar,
   input  logic       auto_faixa,
   input  logic [1:0] faixa_manual,
   input  logic       estouro,
   input  logic       msd_zero,
   output logic       limpar,
   output logic       habilitar,
   output logic       armazena,
   output logic       valido,
   output logic       sobrecarga,
   output logic [1:0] faixa_atual,
   output logic       ocupado
);

   localparam faixa_t FAIXA_MAX = faixa_t'(NUM_FAIXAS - 1);

   estado_t r_estado;
   estado_t w_estado_nxt;
   logic    r_iniciar;
   logic    r_auto;
   logic    r_sticky;
   logic    r_sobrecarga;
   faixa_t  r_faixa;
   logic    w_fim;
   logic    w_sticky_nxt;
   logic    w_suprime;

   contador_janela #(
      .BASE_TICKS(BASE_TICKS)
   ) u_contador (
      .clk     (clk),
      .rst_n   (rst_n),
      .carregar(limpar),
      .faixa   (r_faixa),
      .fim     (w_fim)
   );

   // Overflow seen so far including this cycle; lets ESPERA decide on the
   // settle-cycle carry without waiting another cycle.
   assign w_sticky_nxt = r_sticky | estouro;
   // Autorange discards an overflowed window unless there is no shorter range.
   assign w_suprime    = r_auto & w_sticky_nxt & (r_faixa != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_estado_nxt;
      end
   end

   always_comb begin
      w_estado_nxt = r_estado;
      unique case (r_estado)
         OCIOSO:   if (r_iniciar) w_estado_nxt = LIMPA;
         LIMPA:    w_estado_nxt = JANELA;
         JANELA:   if (w_fim) w_estado_nxt = ESPERA;
         ESPERA:   w_estado_nxt = w_suprime ? AJUSTE : ARMAZENA;
         ARMAZENA: w_estado_nxt = AJUSTE;
         AJUSTE:   w_estado_nxt = r_iniciar ? LIMPA : OCIOSO;
         default:  w_estado_nxt = OCIOSO;
      endcase
   end

   // iniciar is registered so no input reaches the outputs combinationally;
   // this adds the one-cycle start latency before LIMPA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iniciar    <= 1'b0;
         r_auto       <= 1'b0;
         r_sticky     <= 1'b0;
         r_sobrecarga <= 1'b0;
         r_faixa      <= 2'd0;
      end else begin
         r_iniciar <= iniciar;
         case (r_estado)
            OCIOSO: begin
               // Mode and manual range are only picked up while idle.
               r_auto <= auto_faixa;
               if (!auto_faixa) r_faixa <= faixa_manual;
            end
            LIMPA:  r_sticky <= 1'b0;
            JANELA: r_sticky <= w_sticky_nxt;
            ESPERA: begin
               r_sticky <= w_sticky_nxt;
               // Update together with the store so it lines up with valido.
               if (!w_suprime) r_sobrecarga <= w_sticky_nxt;
            end
            AJUSTE: begin
               if (r_auto) begin
                  if (r_sticky && (r_faixa != 2'd0)) begin
                     r_faixa <= r_faixa - 2'd1;
                  end else if (!r_sticky && msd_zero && (r_faixa < FAIXA_MAX)) begin
                     r_faixa <= r_faixa + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign limpar      = (r_estado == LIMPA);
   assign habilitar   = (r_estado == JANELA);
   assign armazena    = (r_estado == ARMAZENA);
   assign valido      = (r_estado == ARMAZENA);
   assign ocupado     = (r_estado != OCIOSO);
   assign sobrecarga  = r_sobrecarga;
   assign faixa_atual = r_faixa;

endmodule

// File: tb/tb_controle_janela.sv
// Self-checking bench for controle_janela with BASE_TICKS = 4. A measurement-level
// model predicts gate length, whether a store happens, the overflow flag and the
// next range; randomized overflow timing and settings exercise it.
module tb_controle_janela;

   localparam int BT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iniciar = 1'b0;
   logic       auto_faixa = 1'b0;
   logic [1:0] faixa_manual = 2'd0;
   logic       estouro = 1'b0;
   logic       msd_zero = 1'b0;
   logic       limpar;
   logic       habilitar;
   logic       armazena;
   logic       valido;
   logic       sobrecarga;
   logic [1:0] faixa_atual;
   logic       ocupado;

   int n_chk = 0;
   int n_ok  = 0;
   int m_faixa = 0;
   bit m_auto  = 1'b0;

   controle_janela #(
      .BASE_TICKS(BT),
      .NUM_FAIXAS(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iniciar     (iniciar),
      .auto_faixa  (auto_faixa),
      .faixa_manual(faixa_manual),
      .estouro     (estouro),
      .msd_zero    (msd_zero),
      .limpar      (limpar),
      .habilitar   (habilitar),
      .armazena    (armazena),
      .valido      (valido),
      .sobrecarga  (sobrecarga),
      .faixa_atual (faixa_atual),
      .ocupado     (ocupado)
   );

   always #5 clk = ~clk;

   task automatic checar(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_ok++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int gate_len(input int f);
      int g = BT;
      for (int i = 0; i < f; i++) g *= 10;
      return g;
   endfunction

   task automatic checar_zeros(input string tag);
      checar({tag, "_limpar"}, limpar, 0);
      checar({tag, "_habilitar"}, habilitar, 0);
      checar({tag, "_armazena"}, armazena, 0);
      checar({tag, "_valido"}, valido, 0);
      checar({tag, "_sobrecarga"}, sobrecarga, 0);
      checar({tag, "_faixa"}, faixa_atual, 0);
      checar({tag, "_ocupado"}, ocupado, 0);
   endtask

   // Start from OCIOSO: load the initial range manually, then select the mode.
   task automatic comecar(input bit auto_v, input int fm, input bit pulso);
      auto_faixa   = 1'b0;
      faixa_manual = 2'(fm);
      repeat (2) @(negedge clk);
      auto_faixa = auto_v;
      m_auto     = auto_v;
      m_faixa    = fm;
      iniciar    = 1'b1;
      @(negedge clk);
      if (pulso) iniciar = 1'b0;
      checar("latencia_limpar_cedo", limpar, 0);
      @(negedge clk);
      checar("latencia_limpar", limpar, 1);
   endtask

   // One full measurement, entered at or before LIMPA, left just after AJUSTE.
   task automatic janela(input bit ovf, input bit msd, input bit ultimo);
      int  n;
      int  ovf_at;
      bit  store;
      n = 0;
      while (!limpar && n < 50) begin
         @(negedge clk);
         n++;
      end
      checar("limpar_visto", limpar, 1);
      checar("faixa_travada", faixa_atual, m_faixa);
      msd_zero = msd;
      ovf_at   = int'($urandom_range(gate_len(m_faixa) - 1, 0));
      @(negedge clk);
      checar("limpar_1ciclo", limpar, 0);
      n = 0;
      while (habilitar && n < 5000) begin
         estouro = ovf && (n == ovf_at);
         @(negedge clk);
         n++;
      end
      estouro = 1'b0;
      checar("gate_len", n, gate_len(m_faixa));
      checar("espera_gap", int'({habilitar, armazena, valido}), 0);
      if (ultimo) iniciar = 1'b0;
      @(negedge clk);
      store = !(m_auto && ovf && m_faixa > 0);
      checar("armazena", armazena, int'(store));
      checar("valido", valido, int'(store));
      if (store) begin
         checar("sobrecarga", sobrecarga, int'(ovf));
         @(negedge clk);
         checar("strobe_1ciclo", armazena, 0);
      end
      checar("ajuste_ocupado", ocupado, 1);
      if (m_auto) begin
         if (ovf && m_faixa > 0) m_faixa--;
         else if (!ovf && msd && m_faixa < 3) m_faixa++;
      end
      @(negedge clk);
      checar("faixa_nova", faixa_atual, m_faixa);
      checar("ocupado_fim", ocupado, int'(!ultimo));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      checar_zeros("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Manual range 0, single-cycle iniciar pulse.
      comecar(1'b0, 0, 1'b1);
      janela(1'b0, 1'b0, 1'b1);

      // Manual range 2, iniciar held: back-to-back windows.
      comecar(1'b0, 2, 1'b0);
      janela(1'b0, 1'b1, 1'b0);
      janela(1'b1, 1'b1, 1'b1);

      // Autorange chain: down on overflow, saturate at 0, climb to 3, saturate.
      comecar(1'b1, 2, 1'b0);
      janela(1'b1, 1'b0, 1'b0);
      janela(1'b0, 1'b0, 1'b0);
      janela(1'b1, 1'b0, 1'b0);
      janela(1'b1, 1'b0, 1'b0);
      janela(1'b0, 1'b1, 1'b0);
      janela(1'b0, 1'b1, 1'b0);
      janela(1'b0, 1'b1, 1'b0);
      janela(1'b0, 1'b1, 1'b1);

      // Reset in the middle of a range-1 window (sobrecarga set beforehand).
      comecar(1'b0, 1, 1'b0);
      janela(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!habilitar && n < 50) begin
         @(negedge clk);
         n++;
      end
      checar("janela_antes_reset", habilitar, 1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checar_zeros("reset_meio");
      iniciar = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checar("reset_sem_armazena", armazena, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checar("reset_ocioso", ocupado, 0);

      // Randomized runs.
      for (int r = 0; r < 4; r++) begin
         comecar(1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 1'b0);
         for (int w = 0; w < 3; w++) begin
            janela(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), w == 2);
         end
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
